// File: rtl/shift_operators.sv
// ============================================================================
//  Module      : shift_operators
//  Description : Registered single-step shifter applying one of four fixed
//                -distance shifts to the operand each clock.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module shift_operators #(
    parameter int WIDTH     = 4,
    parameter int SHIFT_AMT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in,
    input  logic [1:0]       sel,
    output logic [WIDTH-1:0] out
);

    localparam logic [1:0] c_SEL_LSL = 2'b00;
    localparam logic [1:0] c_SEL_LSR = 2'b01;
    localparam logic [1:0] c_SEL_ASL = 2'b10;
    localparam logic [1:0] c_SEL_ASR = 2'b11;

    logic [WIDTH-1:0] w_shifted;
    logic [WIDTH-1:0] r_out;

    always_comb begin
        w_shifted = '0;
        case (sel)
            c_SEL_LSL: w_shifted = in << SHIFT_AMT;
            c_SEL_LSR: w_shifted = in >> SHIFT_AMT;
            c_SEL_ASL: w_shifted = in <<< SHIFT_AMT;
            // Signed cast makes >>> replicate the MSB into the vacated bits.
            c_SEL_ASR: w_shifted = $unsigned($signed(in) >>> SHIFT_AMT);
            default:   w_shifted = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out <= '0;
        end else begin
            r_out <= w_shifted;
        end
    end

    assign out = r_out;

endmodule

`default_nettype wire

// File: tb/tb_shift_operators.sv
// ============================================================================
//  Module      : tb_shift_operators
//  Description : Scoreboard bench driving a 4-bit/k=1 and an 8-bit/k=3 shifter.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_shift_operators;

    logic       clk;
    logic       rst_n;
    logic [3:0] in4;
    logic [1:0] sel4;
    logic [3:0] out4;
    logic [7:0] in8;
    logic [1:0] sel8;
    logic [7:0] out8;

    logic [3:0] q4[$];
    logic [7:0] q8[$];
    int         qid[$];

    int n_vec  = 0;
    int n_err  = 0;
    int vec_id = 0;

    shift_operators #(.WIDTH(4), .SHIFT_AMT(1)) u_dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .in    (in4),
        .sel   (sel4),
        .out   (out4)
    );

    shift_operators #(.WIDTH(8), .SHIFT_AMT(3)) u_dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .in    (in8),
        .sel   (sel8),
        .out   (out8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: the DUT presents a new result every edge, so each edge retires
    // the oldest pending expectation pair.
    always @(posedge clk) begin
        #1;
        if (qid.size() > 0) begin
            int         id;
            logic [3:0] e4;
            logic [7:0] e8;
            id = qid.pop_front();
            e4 = q4.pop_front();
            e8 = q8.pop_front();
            n_vec = n_vec + 1;
            if (out4 !== e4) begin
                n_err = n_err + 1;
                $display("FAIL vec%0d w4: got %b expected %b", id, out4, e4);
            end
            n_vec = n_vec + 1;
            if (out8 !== e8) begin
                n_err = n_err + 1;
                $display("FAIL vec%0d w8: got %b expected %b", id, out8, e8);
            end
        end
    end

    task automatic apply(input logic rst_v,
                         input logic [3:0] i4, input logic [1:0] s4, input logic [3:0] e4,
                         input logic [7:0] i8, input logic [1:0] s8, input logic [7:0] e8);
        @(negedge clk);
        rst_n = rst_v;
        in4   = i4;
        sel4  = s4;
        in8   = i8;
        sel8  = s8;
        q4.push_back(e4);
        q8.push_back(e8);
        qid.push_back(vec_id);
        vec_id = vec_id + 1;
    endtask

    task automatic check_async(input string name);
        n_vec = n_vec + 1;
        if (out4 !== 4'b0000) begin
            n_err = n_err + 1;
            $display("FAIL %s w4: got %b expected 0000", name, out4);
        end
        n_vec = n_vec + 1;
        if (out8 !== 8'b0000_0000) begin
            n_err = n_err + 1;
            $display("FAIL %s w8: got %b expected 00000000", name, out8);
        end
    endtask

    initial begin
        rst_n = 1'b1;
        in4   = 4'b0110;
        sel4  = 2'b00;
        in8   = 8'b1001_0110;
        sel8  = 2'b00;

        // Edge at t=5 loads nonzero values; reset at t=7 must clear them at once.
        #7 rst_n = 1'b0;
        #1 check_async("reset_assert");

        apply(1'b0, 4'b0110, 2'b01, 4'b0000, 8'b1001_0110, 2'b11, 8'b0000_0000);
        apply(1'b0, 4'b0110, 2'b11, 4'b0000, 8'b1111_1111, 2'b00, 8'b0000_0000);

        // Release, then step sel with in held.
        apply(1'b1, 4'b0110, 2'b00, 4'b1100, 8'b1001_0110, 2'b11, 8'b1111_0010);
        apply(1'b1, 4'b0110, 2'b01, 4'b0011, 8'b1001_0110, 2'b00, 8'b1011_0000);
        apply(1'b1, 4'b0110, 2'b10, 4'b1100, 8'b1001_0110, 2'b01, 8'b0001_0010);
        apply(1'b1, 4'b0110, 2'b11, 4'b0011, 8'b1001_0110, 2'b10, 8'b1011_0000);

        apply(1'b1, 4'b1010, 2'b11, 4'b1101, 8'b1000_0001, 2'b11, 8'b1111_0000);
        apply(1'b1, 4'b1010, 2'b01, 4'b0101, 8'b1000_0001, 2'b01, 8'b0001_0000);
        apply(1'b1, 4'b1010, 2'b00, 4'b0100, 8'b1000_0001, 2'b00, 8'b0000_1000);
        apply(1'b1, 4'b1010, 2'b10, 4'b0100, 8'b1000_0001, 2'b10, 8'b0000_1000);

        apply(1'b1, 4'b1111, 2'b00, 4'b1110, 8'b1111_1111, 2'b00, 8'b1111_1000);
        apply(1'b1, 4'b1111, 2'b01, 4'b0111, 8'b1111_1111, 2'b01, 8'b0001_1111);
        apply(1'b1, 4'b1111, 2'b10, 4'b1110, 8'b1111_1111, 2'b10, 8'b1111_1000);
        apply(1'b1, 4'b1111, 2'b11, 4'b1111, 8'b1111_1111, 2'b11, 8'b1111_1111);

        for (int s = 0; s < 4; s++) begin
            apply(1'b1, 4'b0000, 2'(s), 4'b0000, 8'b0000_0000, 2'(s), 8'b0000_0000);
        end

        // MSB clear: arithmetic right matches logical right.
        apply(1'b1, 4'b0101, 2'b11, 4'b0010, 8'b0110_0101, 2'b11, 8'b0000_1100);
        apply(1'b1, 4'b0101, 2'b01, 4'b0010, 8'b0110_0101, 2'b01, 8'b0000_1100);
        apply(1'b1, 4'b1000, 2'b11, 4'b1100, 8'b0110_0101, 2'b00, 8'b0010_1000);

        // Leave nonzero outputs, then assert reset between edges.
        apply(1'b1, 4'b1111, 2'b11, 4'b1111, 8'b1111_1111, 2'b11, 8'b1111_1111);
        apply(1'b1, 4'b1001, 2'b00, 4'b0000, 8'b1001_0110, 2'b00, 8'b0000_0000);
        #2 rst_n = 1'b0;
        #1 check_async("reset_midstream");
        apply(1'b1, 4'b1001, 2'b00, 4'b0010, 8'b1001_0110, 2'b00, 8'b1011_0000);

        begin
            int budget;
            budget = 0;
            while (qid.size() > 0 && budget < 10) begin
                @(negedge clk);
                budget = budget + 1;
            end
            if (qid.size() > 0) begin
                n_err = n_err + 1;
                $display("FAIL drain: got %0d pending expected 0", qid.size());
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
